dds_phase_gen: RTL and testbench



---
 rtl/dds_phase_gen.sv | 195 +++++++++++++++++++
 tb/tb_dds_phase_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_gen.sv
// Phase accumulator feeding an AXI4-Stream phase word; first sample one cycle after enable.
// Output is registered and held stable under backpressure; config changes land only on handshakes.
module dds_phase_gen #(
    parameter int PHASE_W = 32,
    parameter int LEN_W   = 16
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    input  logic               ctrl_enable,
    input  logic               ctrl_sweep_en,
    input  logic [PHASE_W-1:0] cfg_pinc,
    input  logic [PHASE_W-1:0] cfg_poff,
    input  logic [PHASE_W-1:0] cfg_step,
    input  logic [LEN_W-1:0]   cfg_sweep_len,
    input  logic               cfg_commit,
    input  logic               cfg_resync,
    output logic [PHASE_W-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               stat_running,
    output logic               stat_pending,
    output logic               stat_sweep_wrap,
    output logic [31:0]        stat_sample_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_SWEEP = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [PHASE_W-1:0] r_acc, r_tdata, r_pinc_cur;
    logic [PHASE_W-1:0] r_pinc_base, r_poff, r_step;
    logic [PHASE_W-1:0] r_sh_pinc, r_sh_poff, r_sh_step;
    logic [LEN_W-1:0]   r_len, r_sh_len, r_sweep_cnt;
    logic               r_pending, r_resync, r_tvalid, r_wrap;
    logic [31:0]        r_sample_cnt;

    logic               w_hs, w_use_cfg, w_use_sh, w_sweep_mode, w_reload, w_sweep_wrap;
    logic [PHASE_W-1:0] w_eff_pinc, w_eff_poff, w_eff_step;
    logic [PHASE_W-1:0] w_cur_pinc, w_acc_n, w_nxt_pinc;
    logic [LEN_W-1:0]   w_eff_len, w_cur_cnt, w_cnt_dec, w_nxt_cnt;

    assign w_hs = r_tvalid & m_axis_tready;

    // Config seen by this cycle's update: fresh cfg in IDLE, else shadow if pending, else active.
    always_comb begin
        w_use_cfg = (r_state == S_IDLE) && cfg_commit;
        w_use_sh  = r_pending && !w_use_cfg;
        w_eff_pinc = r_pinc_base;
        w_eff_poff = r_poff;
        w_eff_step = r_step;
        w_eff_len  = r_len;
        if (w_use_cfg) begin
            w_eff_pinc = cfg_pinc;
            w_eff_poff = cfg_poff;
            w_eff_step = cfg_step;
            w_eff_len  = cfg_sweep_len;
        end else if (w_use_sh) begin
            w_eff_pinc = r_sh_pinc;
            w_eff_poff = r_sh_poff;
            w_eff_step = r_sh_step;
            w_eff_len  = r_sh_len;
        end
    end

    always_comb begin
        w_sweep_mode = ctrl_sweep_en && (w_eff_len != '0);
        // A new config or a RUN/SWEEP mode change restarts the sweep from the base increment.
        w_reload     = w_use_sh || (w_sweep_mode != (r_state == S_SWEEP));
        w_cur_pinc   = w_reload ? w_eff_pinc : r_pinc_cur;
        w_cur_cnt    = w_reload ? w_eff_len : r_sweep_cnt;
        w_acc_n      = r_resync ? '0 : r_acc + w_cur_pinc;
        w_cnt_dec    = w_cur_cnt - 1'b1;
        w_sweep_wrap = w_sweep_mode && (w_cnt_dec == '0);
        w_nxt_pinc   = w_cur_pinc;
        w_nxt_cnt    = w_cur_cnt;
        if (w_sweep_mode) begin
            w_nxt_pinc = w_sweep_wrap ? w_eff_pinc : w_cur_pinc + w_eff_step;
            w_nxt_cnt  = w_sweep_wrap ? w_eff_len : w_cnt_dec;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (ctrl_enable) w_state_nxt = w_sweep_mode ? S_SWEEP : S_RUN;
            end
            S_RUN, S_SWEEP: begin
                if (!ctrl_enable)  w_state_nxt = w_hs ? S_IDLE : S_DRAIN;
                else if (w_hs)     w_state_nxt = w_sweep_mode ? S_SWEEP : S_RUN;
            end
            S_DRAIN: begin
                if (w_hs) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_acc        <= '0;
            r_tdata      <= '0;
            r_pinc_cur   <= '0;
            r_pinc_base  <= '0;
            r_poff       <= '0;
            r_step       <= '0;
            r_len        <= '0;
            r_sh_pinc    <= '0;
            r_sh_poff    <= '0;
            r_sh_step    <= '0;
            r_sh_len     <= '0;
            r_sweep_cnt  <= '0;
            r_pending    <= 1'b0;
            r_resync     <= 1'b0;
            r_tvalid     <= 1'b0;
            r_wrap       <= 1'b0;
            r_sample_cnt <= '0;
        end else begin
            r_wrap <= 1'b0;
            if (cfg_commit) begin
                r_sh_pinc <= cfg_pinc;
                r_sh_poff <= cfg_poff;
                r_sh_step <= cfg_step;
                r_sh_len  <= cfg_sweep_len;
            end
            case (r_state)
                S_IDLE: begin
                    r_pinc_base <= w_eff_pinc;
                    r_poff      <= w_eff_poff;
                    r_step      <= w_eff_step;
                    r_len       <= w_eff_len;
                    r_pending   <= 1'b0;
                    r_resync    <= 1'b0;
                    if (ctrl_enable) begin
                        r_acc        <= '0;
                        r_pinc_cur   <= w_eff_pinc;
                        r_sweep_cnt  <= w_eff_len;
                        r_sample_cnt <= '0;
                        r_tdata      <= w_eff_poff;
                        r_tvalid     <= 1'b1;
                    end
                end
                S_RUN, S_SWEEP: begin
                    if (w_hs && ctrl_enable) begin
                        r_sample_cnt <= r_sample_cnt + 32'd1;
                        r_pinc_base  <= w_eff_pinc;
                        r_poff       <= w_eff_poff;
                        r_step       <= w_eff_step;
                        r_len        <= w_eff_len;
                        r_pending    <= cfg_commit;
                        r_acc        <= w_acc_n;
                        r_tdata      <= w_acc_n + w_eff_poff;
                        r_pinc_cur   <= w_nxt_pinc;
                        r_sweep_cnt  <= w_nxt_cnt;
                        r_wrap       <= w_sweep_wrap;
                        r_resync     <= cfg_resync;
                    end else if (w_hs) begin
                        r_sample_cnt <= r_sample_cnt + 32'd1;
                        r_tvalid     <= 1'b0;
                        r_pending    <= r_pending | cfg_commit;
                    end else begin
                        r_pending <= r_pending | cfg_commit;
                        r_resync  <= r_resync | cfg_resync;
                    end
                end
                S_DRAIN: begin
                    r_pending <= r_pending | cfg_commit;
                    if (w_hs) begin
                        r_sample_cnt <= r_sample_cnt + 32'd1;
                        r_tvalid     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axis_tdata    = r_tdata;
    assign m_axis_tvalid   = r_tvalid;
    assign stat_running    = (r_state == S_RUN) || (r_state == S_SWEEP);
    assign stat_pending    = r_pending;
    assign stat_sweep_wrap = r_wrap;
    assign stat_sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed bench for dds_phase_gen: constant rate, backpressure, commit, sweep, resync, drain, reset.
module tb_dds_phase_gen;

    localparam int PW = 32;
    localparam int LW = 16;

    logic          ACLK = 1'b0;
    logic          ARESETN;
    logic          ctrl_enable, ctrl_sweep_en;
    logic [PW-1:0] cfg_pinc, cfg_poff, cfg_step;
    logic [LW-1:0] cfg_sweep_len;
    logic          cfg_commit, cfg_resync;
    logic [PW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready;
    logic          stat_running, stat_pending, stat_sweep_wrap;
    logic [31:0]   stat_sample_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] sw_exp  [6] = '{32'h0, 32'h100, 32'h210, 32'h330, 32'h430, 32'h540};
    logic [31:0] sw_wrap [6] = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0};

    dds_phase_gen #(.PHASE_W(PW), .LEN_W(LW)) dut (
        .ACLK            (ACLK),
        .ARESETN         (ARESETN),
        .ctrl_enable     (ctrl_enable),
        .ctrl_sweep_en   (ctrl_sweep_en),
        .cfg_pinc        (cfg_pinc),
        .cfg_poff        (cfg_poff),
        .cfg_step        (cfg_step),
        .cfg_sweep_len   (cfg_sweep_len),
        .cfg_commit      (cfg_commit),
        .cfg_resync      (cfg_resync),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .stat_running    (stat_running),
        .stat_pending    (stat_pending),
        .stat_sweep_wrap (stat_sweep_wrap),
        .stat_sample_cnt (stat_sample_cnt)
    );

    initial forever #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        ARESETN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ctrl_enable   = 1'($urandom);
            ctrl_sweep_en = 1'($urandom);
            cfg_pinc      = $urandom;
            cfg_poff      = $urandom;
            cfg_step      = $urandom;
            cfg_sweep_len = LW'($urandom);
            cfg_commit    = 1'($urandom);
            cfg_resync    = 1'($urandom);
            m_axis_tready = 1'($urandom);
            tick();
        end
        chk("rst_tdata", m_axis_tdata, 32'h0);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_running", 32'(stat_running), 32'd0);
        chk("rst_pending", 32'(stat_pending), 32'd0);
        chk("rst_wrap", 32'(stat_sweep_wrap), 32'd0);
        chk("rst_cnt", stat_sample_cnt, 32'd0);

        ctrl_enable = 1'b0; ctrl_sweep_en = 1'b0;
        cfg_pinc = '0; cfg_poff = '0; cfg_step = '0; cfg_sweep_len = '0;
        cfg_commit = 1'b0; cfg_resync = 1'b0; m_axis_tready = 1'b0;
        ARESETN = 1'b1;
        repeat (3) tick();
        chk("idle_tvalid", 32'(m_axis_tvalid), 32'd0);

        // Constant rate with wrap after 16 samples
        cfg_pinc = 32'h1000_0000; cfg_poff = 32'h5; cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("idle_commit_pending", 32'(stat_pending), 32'd0);
        ctrl_enable = 1'b1; m_axis_tready = 1'b1;
        tick();
        chk("run_running", 32'(stat_running), 32'd1);
        for (int i = 0; i < 17; i++) begin
            chk("const_tdata", m_axis_tdata, 32'(i) * 32'h1000_0000 + 32'h5);
            if (i == 16) chk("const_cnt_at_wrap", stat_sample_cnt, 32'd16);
            tick();
        end

        // Backpressure holds sample 17
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_tdata", m_axis_tdata, 32'h1000_0005);
            chk("bp_hold_tvalid", 32'(m_axis_tvalid), 32'd1);
        end
        m_axis_tready = 1'b1;
        tick();
        chk("bp_resume1", m_axis_tdata, 32'h2000_0005);
        tick();
        chk("bp_resume2", m_axis_tdata, 32'h3000_0005);
        chk("bp_cnt", stat_sample_cnt, 32'd19);
        ctrl_enable = 1'b0;
        tick();
        chk("stop_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("stop_running", 32'(stat_running), 32'd0);

        // Commit mid-stream
        cfg_pinc = 32'h100; cfg_poff = 32'h0; cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0; ctrl_enable = 1'b1;
        tick();
        chk("cm_first", m_axis_tdata, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("cm_ramp", m_axis_tdata, 32'(k) * 32'h100);
        end
        m_axis_tready = 1'b0; cfg_pinc = 32'h200; cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("cm_pending_set", 32'(stat_pending), 32'd1);
        chk("cm_held", m_axis_tdata, 32'h300);
        m_axis_tready = 1'b1;
        tick();
        chk("cm_applied", m_axis_tdata, 32'h500);
        chk("cm_pending_clr", 32'(stat_pending), 32'd0);
        cfg_pinc = 32'h100; cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("cm_coinc_old", m_axis_tdata, 32'h700);
        chk("cm_coinc_pending", 32'(stat_pending), 32'd1);
        tick();
        chk("cm_coinc_new", m_axis_tdata, 32'h800);
        chk("cm_coinc_clr", 32'(stat_pending), 32'd0);
        ctrl_enable = 1'b0;
        tick();

        // Linear sweep, then resync
        cfg_pinc = 32'h100; cfg_step = 32'h10; cfg_sweep_len = 16'd3; cfg_poff = 32'h0;
        ctrl_sweep_en = 1'b1; cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0; ctrl_enable = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            chk("sw_tdata", m_axis_tdata, sw_exp[i]);
            chk("sw_wrap", 32'(stat_sweep_wrap), sw_wrap[i]);
            if (i < 5) tick();
        end
        m_axis_tready = 1'b0; cfg_resync = 1'b1;
        tick();
        cfg_resync = 1'b0;
        chk("rs_held", m_axis_tdata, 32'h540);
        m_axis_tready = 1'b1;
        tick();
        chk("rs_zero", m_axis_tdata, 32'h0);
        chk("rs_wrap", 32'(stat_sweep_wrap), 32'd1);
        tick();
        chk("rs_next", m_axis_tdata, 32'h100);

        // Disable under backpressure -> drain
        m_axis_tready = 1'b0; ctrl_enable = 1'b0;
        tick();
        chk("dr_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("dr_running", 32'(stat_running), 32'd0);
        chk("dr_tdata", m_axis_tdata, 32'h100);
        ctrl_enable = 1'b1;
        tick();
        chk("dr_reenable_ignored", 32'(m_axis_tvalid), 32'd1);
        chk("dr_reenable_running", 32'(stat_running), 32'd0);
        m_axis_tready = 1'b1;
        tick();
        chk("dr_done_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("dr_done_running", 32'(stat_running), 32'd0);
        tick();
        chk("re_first", m_axis_tdata, 32'h0);
        chk("re_cnt", stat_sample_cnt, 32'd0);
        tick();
        chk("re_s1", m_axis_tdata, 32'h100);
        tick();
        chk("re_s2", m_axis_tdata, 32'h210);

        // Asynchronous reset mid-sweep
        ctrl_enable = 1'b0;
        ARESETN = 1'b0;
        #2;
        chk("arst_tdata", m_axis_tdata, 32'h0);
        chk("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("arst_running", 32'(stat_running), 32'd0);
        chk("arst_cnt", stat_sample_cnt, 32'd0);
        ARESETN = 1'b1;
        tick();
        tick();
        chk("arst_idle_tvalid", 32'(m_axis_tvalid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
